// File: rtl/ps_bigreg_assembler_if.sv
// rtl/ps_bigreg_assembler_if.sv - PS write path, response and assembled-register handshake bundle
interface ps_bigreg_assembler_if #(
    parameter int SAMPLES = 16,
    parameter int WORD_W  = 16,
    parameter int ID_W    = 8
);
    logic                      wr_en;
    logic [ID_W-1:0]           wr_id;
    logic [WORD_W-1:0]         wr_data;
    logic                      resp_valid;
    logic [1:0]                resp;
    logic [SAMPLES:0]          fresh_clr;
    logic [SAMPLES*WORD_W-1:0] out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SAMPLES-1:0]        staged;

    modport master (
        output wr_en, wr_id, wr_data, out_ready,
        input  resp_valid, resp, fresh_clr, out_data, out_valid, staged
    );

    modport slave (
        input  wr_en, wr_id, wr_data, out_ready,
        output resp_valid, resp, fresh_clr, out_data, out_valid, staged
    );
endinterface

// File: rtl/ps_bigreg_assembler.sv
// rtl/ps_bigreg_assembler.sv - stages PS word writes into a double-buffered wide register
// Optional staging timeout enabled by defining BIGREG_TIMEOUT_EN.
module ps_bigreg_assembler #(
    parameter int BASE_ID        = 1,
    parameter int SAMPLES        = 16,
    parameter int WORD_W         = 16,
    parameter int ID_W           = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                    clk,
    input logic                    rst_n,
    ps_bigreg_assembler_if.slave   bus
);
    localparam int IDX_W  = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam int DATA_W = SAMPLES * WORD_W;
    localparam logic [ID_W-1:0] FIRST_ID = ID_W'(BASE_ID);
    localparam logic [ID_W-1:0] VALID_ID = ID_W'(BASE_ID + SAMPLES);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {S_IDLE, S_HOLD} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   stage_q, stage_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [SAMPLES-1:0]  fresh_q, fresh_d;
    logic                resp_valid_q, resp_valid_d;
    logic [1:0]          resp_q, resp_d;
    logic [SAMPLES:0]    fresh_clr_q, fresh_clr_d;

    logic                data_wr;
    logic                valid_wr;
    logic                handshake;
    logic                commit;
    logic [IDX_W-1:0]    word_idx;

`ifdef BIGREG_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    assign data_wr   = bus.wr_en && (bus.wr_id >= FIRST_ID) && (bus.wr_id < VALID_ID);
    assign valid_wr  = bus.wr_en && (bus.wr_id == VALID_ID);
    assign word_idx  = IDX_W'(bus.wr_id - FIRST_ID);
    assign handshake = (state_q == S_HOLD) && bus.out_ready;
    // The consumer handshake frees the output register before the commit is judged.
    assign commit    = valid_wr && (&fresh_q) && ((state_q == S_IDLE) || handshake);

    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        fresh_d      = fresh_q;
        out_data_d   = out_data_q;
        resp_valid_d = 1'b0;
        resp_d       = RESP_OKAY;
        fresh_clr_d  = '0;
`ifdef BIGREG_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif

        if (handshake) begin
            state_d = S_IDLE;
        end

        if (data_wr) begin
            resp_valid_d = 1'b1;
            for (int k = 0; k < SAMPLES; k++) begin
                if (word_idx == IDX_W'(k)) begin
                    stage_d[k*WORD_W +: WORD_W] = bus.wr_data;
                    fresh_d[k]                  = 1'b1;
                end
            end
        end

        if (valid_wr) begin
            resp_valid_d = 1'b1;
            if (commit) begin
                out_data_d  = stage_q;
                fresh_d     = '0;
                state_d     = S_HOLD;
                fresh_clr_d = '1;
            end else begin
                resp_d      = RESP_SLVERR;
                fresh_clr_d = {1'b1, {SAMPLES{1'b0}}};
            end
        end

`ifdef BIGREG_TIMEOUT_EN
        // A data write restarts the window; an idle non-empty mask ages until it is dropped.
        if (commit || data_wr || (fresh_q == '0)) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            cnt_d   = '0;
            fresh_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            stage_q      <= '0;
            out_data_q   <= '0;
            fresh_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_q       <= RESP_OKAY;
            fresh_clr_q  <= '0;
`ifdef BIGREG_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            out_data_q   <= out_data_d;
            fresh_q      <= fresh_d;
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
            fresh_clr_q  <= fresh_clr_d;
`ifdef BIGREG_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp       = resp_q;
    assign bus.fresh_clr  = fresh_clr_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = (state_q == S_HOLD);
    assign bus.staged     = fresh_q;
endmodule

// File: tb/tb_ps_bigreg_assembler.sv
// tb/tb_ps_bigreg_assembler.sv - randomized and directed checks against a word-array reference model
module tb_ps_bigreg_assembler;
`ifdef BIGREG_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 4096;
`endif

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    ps_bigreg_assembler_if #(.SAMPLES(16), .WORD_W(16), .ID_W(8)) bus ();

    ps_bigreg_assembler #(
        .BASE_ID(1), .SAMPLES(16), .WORD_W(16), .ID_W(8), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0]  st_m [16];
    logic [15:0]  fr_m;
    bit           hold_m;
    logic [255:0] out_m;
    bit           e_rv;
    logic [1:0]   e_resp;
    logic [16:0]  e_fc;
    int           age_m;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) st_m[k] = '0;
        fr_m   = '0;
        hold_m = 1'b0;
        out_m  = '0;
        e_rv   = 1'b0;
        e_resp = 2'b00;
        e_fc   = '0;
        age_m  = 0;
    endtask

    task automatic model_step(input bit en, input logic [7:0] id, input logic [15:0] d, input bit rdy);
        bit wrote;
        bit committed;
        wrote     = 1'b0;
        committed = 1'b0;
        e_rv      = 1'b0;
        e_resp    = 2'b00;
        e_fc      = '0;
        if (hold_m && rdy) hold_m = 1'b0;
        if (en && id >= 8'd1 && id <= 8'd16) begin
            st_m[id-1]     = d;
            fr_m[id-1]     = 1'b1;
            e_rv           = 1'b1;
            wrote          = 1'b1;
        end else if (en && id == 8'd17) begin
            e_rv = 1'b1;
            if (fr_m == 16'hFFFF && !hold_m) begin
                for (int k = 0; k < 16; k++) out_m[k*16 +: 16] = st_m[k];
                fr_m      = '0;
                hold_m    = 1'b1;
                e_fc      = 17'h1FFFF;
                committed = 1'b1;
            end else begin
                e_resp = 2'b10;
                e_fc   = 17'h10000;
            end
        end
`ifdef BIGREG_TIMEOUT_EN
        if (wrote || committed || fr_m == '0 && !wrote) begin
            age_m = 0;
        end else begin
            age_m++;
            if (age_m == TO) begin
                fr_m  = '0;
                age_m = 0;
            end
        end
`else
        age_m = wrote ? 0 : age_m;
`endif
    endtask

    task automatic cyc(input bit en, input logic [7:0] id, input logic [15:0] d, input bit rdy);
        bus.wr_en     = en;
        bus.wr_id     = id;
        bus.wr_data   = d;
        bus.out_ready = rdy;
        model_step(en, id, d, rdy);
        @(posedge clk);
        #1;
        check("resp_valid", 256'(bus.resp_valid), 256'(e_rv));
        check("resp", 256'(bus.resp), 256'(e_resp));
        check("fresh_clr", 256'(bus.fresh_clr), 256'(e_fc));
        check("out_valid", 256'(bus.out_valid), 256'(hold_m));
        check("out_data", bus.out_data, out_m);
        check("staged", 256'(bus.staged), 256'(fr_m));
    endtask

    task automatic stage_all(input bit rdy);
        for (int k = 1; k <= 16; k++) cyc(1'b1, 8'(k), 16'($urandom), rdy);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rv"}, 256'(bus.resp_valid), 256'(0));
        check({tag, "_resp"}, 256'(bus.resp), 256'(0));
        check({tag, "_fc"}, 256'(bus.fresh_clr), 256'(0));
        check({tag, "_ov"}, 256'(bus.out_valid), 256'(0));
        check({tag, "_od"}, bus.out_data, 256'(0));
        check({tag, "_staged"}, 256'(bus.staged), 256'(0));
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_id     = '0;
        bus.wr_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Full assembly with consumer ready
        for (int k = 1; k <= 16; k++) cyc(1'b1, 8'(k), 16'(16'h1000 + k), 1'b1);
        cyc(1'b1, 8'd17, 16'h0, 1'b1);
        check("t1_fc_all", 256'(bus.fresh_clr), 256'(17'h1FFFF));
        check("t1_word_id5", 256'(bus.out_data[4*16 +: 16]), 256'(16'h1005));
        check("t1_word_id16", 256'(bus.out_data[15*16 +: 16]), 256'(16'h1010));
        cyc(1'b0, 8'd0, 16'h0, 1'b1);
        check("t1_ov_one_cycle", 256'(bus.out_valid), 256'(0));

        // Incomplete staging
        for (int k = 1; k <= 15; k++) cyc(1'b1, 8'(k), 16'($urandom), 1'b1);
        cyc(1'b1, 8'd17, 16'h0, 1'b1);
        check("t2_resp", 256'(bus.resp), 256'(2'b10));
        check("t2_fc", 256'(bus.fresh_clr), 256'(17'h10000));
        check("t2_staged", 256'(bus.staged), 256'(16'h7FFF));
        check("t2_ov", 256'(bus.out_valid), 256'(0));

        // Commit while consumer stalled, then restage and retry
        cyc(1'b1, 8'd16, 16'($urandom), 1'b0);
        cyc(1'b1, 8'd17, 16'h0, 1'b0);
        stage_all(1'b0);
        cyc(1'b1, 8'd17, 16'h0, 1'b0);
        check("t3_slverr", 256'(bus.resp), 256'(2'b10));
        check("t3_staged_kept", 256'(bus.staged), 256'(16'hFFFF));
        cyc(1'b0, 8'd0, 16'h0, 1'b1);
        cyc(1'b1, 8'd17, 16'h0, 1'b0);
        check("t3_second_ok", 256'(bus.resp), 256'(2'b00));

        // Commit in the same cycle as the handshake
        stage_all(1'b0);
        cyc(1'b1, 8'd17, 16'h0, 1'b1);
        check("t4_ov_stays", 256'(bus.out_valid), 256'(1));
        check("t4_resp", 256'(bus.resp), 256'(2'b00));
        cyc(1'b0, 8'd0, 16'h0, 1'b1);

        // Out-of-range ids are ignored
        cyc(1'b1, 8'd4, 16'hBEEF, 1'b0);
        cyc(1'b1, 8'd0, 16'h1234, 1'b0);
        check("t5_id0_norsp", 256'(bus.resp_valid), 256'(0));
        cyc(1'b1, 8'd18, 16'h5678, 1'b0);
        check("t5_id18_norsp", 256'(bus.resp_valid), 256'(0));
        check("t5_staged", 256'(bus.staged), 256'(16'h0008));

        // Asynchronous reset with a write in flight
        bus.wr_en   = 1'b1;
        bus.wr_id   = 8'd7;
        bus.wr_data = 16'hAAAA;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_zero_outputs("midreset");
        bus.wr_en = 1'b0;
        @(posedge clk);
        #1;
        check_zero_outputs("midreset_edge");
        rst_n = 1'b1;

`ifdef BIGREG_TIMEOUT_EN
        cyc(1'b1, 8'd3, 16'h3333, 1'b0);
        repeat (16) cyc(1'b0, 8'd0, 16'h0, 1'b0);
        check("to_expired", 256'(bus.staged), 256'(0));
        for (int r = 0; r < 4; r++) begin
            cyc(1'b1, 8'd3, 16'(16'h3000 + r), 1'b0);
            repeat (9) cyc(1'b0, 8'd0, 16'h0, 1'b0);
        end
        check("to_retained", 256'(bus.staged), 256'(16'h0004));
`endif

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom % 4) != 0, 8'($urandom_range(0, 18)), 16'($urandom), ($urandom % 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ps_bigreg_assembler.md
# ps_bigreg_assembler

Collects a sequence of 16-bit memory-map writes from the PS into one wide register, for example the 16-word RNG seed block or the 16-word sample-discriminator config. On a write to the block's valid index, it presents the full register to the RTL consumer over a valid/ready handshake. It sits directly downstream of the AXI-Lite memory-map write path and upstream of the consumer (seed generator, sample discriminator, channel mux). It also produces the per-transaction response code and the fresh-bit clear strobe for the mem map.

## Interface
- `BASE_ID`, 1: mem-map index of word 0.
- `SAMPLES`, 16: number of data words; the valid index is `BASE_ID+SAMPLES`.
- `WORD_W`, 16: width of each data word.
- `ID_W`, 8: index width, equal to clog2(MEM_SIZE).
- `TIMEOUT_CYCLES`, 4096: staging timeout; used only when the timeout macro is defined.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  one-cycle strobe marking a PS write.
- `wr_id`  in  ID_W  mem-map index of the write.
- `wr_data`  in  WORD_W  write data; only the low WORD_W bits are used.
- `resp_valid`  out  1  one-cycle pulse qualifying `resp`.
- `resp`  out  2  response code: 00 OKAY, 10 SLVERR.
- `fresh_clr`  out  SAMPLES+1  one-cycle pulse that clears mem-map fresh bits for words and the valid index.
- `out_data`  out  SAMPLES*WORD_W  assembled register; word k occupies bits [k*WORD_W +: WORD_W].
- `out_valid`  out  1  assembled register is available.
- `out_ready`  in  1  consumer accepts the register.
- `staged`  out  SAMPLES  fresh mask of the staging words (status and debug).

## Operation
- Staging buffer: SAMPLES words, each with a fresh bit. A write with `wr_id` in [BASE_ID, BASE_ID+SAMPLES-1] stores `wr_data` into word `wr_id-BASE_ID` and sets its fresh bit. Response is OKAY. Rewriting a fresh word overwrites it, still OKAY.
- Writes with `wr_id` outside [BASE_ID, BASE_ID+SAMPLES] are ignored: no response, no state change.
- Output register and staging buffer are separate (double-buffered), so staging proceeds while `out_valid` is high.
- States:
  - IDLE: `out_valid`=0.
  - HOLD: `out_valid`=1.
- Valid write (`wr_id`=BASE_ID+SAMPLES):
  - All fresh and state IDLE: copy staging to `out_data`, clear all fresh bits, go to HOLD, respond OKAY, pulse `fresh_clr` all-ones.
  - Not all fresh: respond SLVERR; staging, state and outputs are unchanged; pulse `fresh_clr` with only bit SAMPLES (the valid index) set.
  - State HOLD (consumer has not taken the previous register): respond SLVERR; staging is kept; pulse `fresh_clr` bit SAMPLES only.
- HOLD to IDLE when `out_valid && out_ready`. `out_data` holds its value after the handshake until the next commit.
- Valid write in the same cycle as the HOLD handshake: the handshake is evaluated first, so the commit succeeds if all words are fresh. `out_valid` stays high and `out_data` updates next cycle.
- `wr_en` is guaranteed to be at most one write per cycle; two writes never arrive simultaneously.

## Timing
- Reset values:
  - `out_valid`=0
  - `out_data`=0
  - `staged`=0
  - `resp_valid`=0
  - `resp`=00
  - `fresh_clr`=0
  - state IDLE
  - timeout counter 0
- All outputs are registered.
- `resp_valid`, `resp` and `fresh_clr` assert on the cycle after `wr_en`, for exactly one cycle.
- `out_valid` and the new `out_data` appear the cycle after a committing valid write.
- `out_valid` deasserts the cycle after the handshake.
- Reset mid-operation (in staging or HOLD) discards all words and the pending output; there is no response for an in-flight write.

## Configuration
- `BIGREG_TIMEOUT_EN` defined:
  - A counter starts at the first fresh bit set and restarts on each accepted data write.
  - When it reaches TIMEOUT_CYCLES with the mask nonzero and no commit, all fresh bits clear, with no response and no `fresh_clr` pulse.
  - A commit or an all-zero mask stops and zeroes the counter.
- Undefined: no counter; staged words persist indefinitely until committed or reset.

## Test plan
- Write ids 1..16 with data 0x1000+k, then id 17, with `out_ready`=1:
  - 17 OKAY responses.
  - `out_valid` for 1 cycle.
  - `out_data` word k = 0x1000+k.
  - `fresh_clr`=0x1FFFF once.
- Write ids 1..15 only, then id 17: SLVERR, `fresh_clr`=0x10000, `out_valid` stays 0, `staged`=0x7FFF.
- Commit with `out_ready`=0, restage all 16 words, write id 17:
  - SLVERR; `out_data` unchanged.
  - Assert `out_ready`, write id 17 again: second commit OKAY.
- Hold `out_ready`=0 after a commit, then in one cycle assert `out_ready` together with a valid write of a fully staged buffer: `out_valid` stays 1 and `out_data` updates the next cycle.
- Write id 0 and id 18: no `resp_valid`, no state change.
- With `BIGREG_TIMEOUT_EN` and TIMEOUT_CYCLES=16:
  - Write id 3, idle 16 cycles: `staged` returns to 0.
  - Repeat with a write every 10 cycles: mask is retained.
